// File: rtl/ram_sp_burst_master_if.sv
// Signal bundle for ram_sp_burst_master: command, write stream, read stream, status and RAM port.
// Handshakes: a command or beat transfers on a rising clock edge where valid && ready are both high;
// valid never waits on ready, and the payload stays stable while valid is high and ready is low.
interface ram_sp_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  ram_cen;
    logic                  ram_wen;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done, err,
               ram_cen, ram_wen, ram_addr, ram_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, done, err,
               ram_cen, ram_wen, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_sp_burst_master.sv
// Burst initiator for a single-port synchronous-read RAM; write and read bursts over valid/ready streams.
// Optional build macro RAM_BURST_BOUND_CHECK_EN: reject commands that run past DEPTH instead of wrapping.
module ram_sp_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_sp_burst_master_if.master bus,
    output logic [1:0]            dbg_state
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RD_DRAIN = 2'd3} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [CNT_WIDTH-1:0]  rem_q, rem_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  pop_idx;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            buf_cnt;
    logic                  done_q, done_nxt, err_q, err_nxt;
    logic                  accept, reject, issue, pop;
    logic [2:0]            occ;

`ifdef RAM_BURST_BOUND_CHECK_EN
    localparam int SUM_WIDTH = ADDR_WIDTH + LEN_WIDTH + 1;
    logic [SUM_WIDTH-1:0] end_sum;
    assign end_sum = SUM_WIDTH'(bus.cmd_addr) + SUM_WIDTH'(bus.cmd_len) + SUM_WIDTH'(1);
    assign reject  = end_sum > SUM_WIDTH'(DEPTH);
`else
    assign reject = 1'b0;
`endif

    assign bus.rd_valid = (buf_cnt != 2'd0);
    assign bus.rd_data  = buf_mem[rd_ptr];
    assign bus.rd_last  = bus.rd_valid && (pop_idx == {1'b0, len_q});
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign dbg_state    = state;

    assign pop = bus.rd_valid && bus.rd_ready;
    // Buffered plus in-flight beats; a pop this cycle frees a slot for a same-cycle issue.
    assign occ = {1'b0, buf_cnt} + {2'b00, inflight};

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        rem_nxt       = rem_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        accept        = 1'b0;
        issue         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.ram_cen   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_din   = '0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (reject) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end else begin
                        addr_nxt  = bus.cmd_addr;
                        rem_nxt   = CNT_WIDTH'(bus.cmd_len) + CNT_WIDTH'(1);
                        state_nxt = bus.cmd_write ? WR : RD;
                    end
                end
            end
            WR: begin
                bus.wr_ready = 1'b1;
                bus.ram_cen  = bus.wr_valid;
                bus.ram_wen  = bus.wr_valid;
                bus.ram_addr = addr_q;
                bus.ram_din  = bus.wr_data;
                if (bus.wr_valid) begin
                    addr_nxt = addr_q + ADDR_WIDTH'(1);
                    rem_nxt  = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            RD: begin
                if (occ < (3'd2 + {2'b00, pop})) begin
                    issue        = 1'b1;
                    bus.ram_cen  = 1'b1;
                    bus.ram_addr = addr_q;
                    addr_nxt     = addr_q + ADDR_WIDTH'(1);
                    rem_nxt      = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pop && bus.rd_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            pop_idx    <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_cnt    <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            rem_q    <= rem_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            inflight <= issue;
            if (accept && !reject) begin
                len_q   <= bus.cmd_len;
                pop_idx <= '0;
            end else if (pop) begin
                pop_idx <= pop_idx + CNT_WIDTH'(1);
            end
            // RAM data is registered, so it lands in the buffer one cycle after its issue.
            if (inflight) begin
                buf_mem[wr_ptr] <= bus.ram_dout;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_ram_sp_burst_master.sv
// Directed bench for ram_sp_burst_master with a behavioural single-port RAM (one-cycle registered read).
module tb_ram_sp_burst_master;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 4;
    localparam int AW    = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       ram_preload;
    logic [1:0] dbg_state;

    ram_sp_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ram_sp_burst_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    // RAM model: preloaded with 0x100+i, not touched by reset.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_dout_q;
    always @(posedge clock) begin
        if (ram_preload) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(32'h100 + i);
        end else if (bus.ram_cen) begin
            if (bus.ram_wen) ram[bus.ram_addr] <= bus.ram_din;
            else             ram_dout_q <= ram[bus.ram_addr];
        end
    end
    assign bus.ram_dout = ram_dout_q;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    bit            last_q[$];
    logic [AW-1:0] addr_seen[$];
    logic [DW-1:0] din_seen[$];
    int first_cen, last_cen, first_valid, first_pop, last_pop;
    int done_cyc, done_cnt, err_cyc, err_cnt, max_out;
    bit stall_seen, timed_out, hs_ok, wen_ok;

    task automatic clear_obs();
        got_q.delete(); last_q.delete(); addr_seen.delete(); din_seen.delete();
        first_cen = -1; last_cen = -1; first_valid = -1; first_pop = -1; last_pop = -1;
        done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0; max_out = 0;
        stall_seen = 1'b0; timed_out = 1'b0; hs_ok = 1'b0; wen_ok = 1'b1;
    endtask

    // Driver: one write burst with wr_valid held high, data d0, d0+1, ...
    task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d0);
        int cyc, sent, beats;
        clear_obs();
        beats = int'(l) + 1;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = a; bus.cmd_len = l;
        @(negedge clock);
        hs_ok = bus.cmd_ready;
        cyc = 0; sent = 0;
        while (1) begin
            @(posedge clock); #1;
            bus.cmd_valid = 1'b0;
            bus.wr_valid  = (sent < beats);
            bus.wr_data   = d0 + DW'(sent);
            cyc++;
            @(negedge clock);
            if (bus.ram_cen) begin
                addr_seen.push_back(bus.ram_addr);
                din_seen.push_back(bus.ram_din);
                if (!bus.ram_wen) wen_ok = 1'b0;
                if (first_cen < 0) first_cen = cyc;
                last_cen = cyc;
            end
            if (bus.wr_valid && bus.wr_ready) sent++;
            if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (cyc >= 100) begin timed_out = 1'b1; break; end
        end
        bus.wr_valid = 1'b0;
    endtask

    // Driver: one read burst; mode 0 keeps rd_ready high, mode 1 uses 1,0,0 from the first possible beat.
    task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode, input int abort_after);
        int cyc, issued, popped;
        clear_obs();
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = a; bus.cmd_len = l;
        @(negedge clock);
        hs_ok = bus.cmd_ready;
        cyc = 0; issued = 0; popped = 0;
        while (1) begin
            @(posedge clock); #1;
            bus.cmd_valid = 1'b0;
            cyc++;
            bus.rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            @(negedge clock);
            if (bus.ram_cen) begin
                addr_seen.push_back(bus.ram_addr);
                if (first_cen < 0) first_cen = cyc;
                if (!bus.ram_wen) issued++;
            end else if (issued - popped == 2 && issued < int'(l) + 1) begin
                stall_seen = 1'b1;
            end
            if (bus.rd_valid && first_valid < 0) first_valid = cyc;
            if (bus.rd_valid && bus.rd_ready) begin
                got_q.push_back(bus.rd_data);
                last_q.push_back(bus.rd_last);
                popped++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (bus.err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
            if (abort_after > 0 && popped == abort_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (cyc >= 200) begin timed_out = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        tests_run++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.rd_valid, bus.rd_last, bus.ram_cen, bus.ram_wen, bus.wr_ready} !== 9'b100000000) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 100000000", {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.rd_valid, bus.rd_last, bus.ram_cen, bus.ram_wen, bus.wr_ready});
        end
        tests_run++;
        if (bus.rd_data !== '0) begin tests_failed++; $display("FAIL reset_rd_data: got %0h expected 0", bus.rd_data); end
        tests_run++;
        if ({bus.ram_addr, bus.ram_din} !== '0) begin tests_failed++; $display("FAIL reset_ram_bus: got addr %0h din %0h expected 0", bus.ram_addr, bus.ram_din); end
        tests_run++;
        if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_write_burst();
        run_write(4'd2, 4'd3, 32'hA0);
        tests_run++;
        if (!hs_ok || timed_out) begin tests_failed++; $display("FAIL wr_handshake: hs %0b timeout %0b expected 1/0", hs_ok, timed_out); end
        tests_run++;
        if (first_cen != 1 || last_cen != 4) begin tests_failed++; $display("FAIL wr_cen_window: got %0d..%0d expected 1..4", first_cen, last_cen); end
        tests_run++;
        if (addr_seen.size() != 4 || !wen_ok) begin tests_failed++; $display("FAIL wr_beats: got %0d wen_ok %0b expected 4 and 1", addr_seen.size(), wen_ok); end
        for (int i = 0; i < 4 && i < addr_seen.size(); i++) begin
            tests_run++;
            if (addr_seen[i] !== AW'(2 + i) || din_seen[i] !== DW'(32'hA0 + i)) begin
                tests_failed++; $display("FAIL wr_beat%0d: got addr %0d din %0h expected %0d %0h", i, addr_seen[i], din_seen[i], 2 + i, 32'hA0 + i);
            end
        end
        tests_run++;
        if (done_cyc != 5 || done_cnt != 1) begin tests_failed++; $display("FAIL wr_done: got cycle %0d count %0d expected 5 1", done_cyc, done_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ram[2 + i] !== DW'(32'hA0 + i)) begin tests_failed++; $display("FAIL wr_ram%0d: got %0h expected %0h", 2 + i, ram[2 + i], 32'hA0 + i); end
        end
    endtask

    task automatic test_read_burst();
        run_read(4'd2, 4'd3, 0, 0);
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        tests_run++;
        if (!hs_ok || timed_out || got_q.size() != 4) begin tests_failed++; $display("FAIL rd_count: got %0d beats hs %0b timeout %0b expected 4 1 0", got_q.size(), hs_ok, timed_out); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3)) begin
                tests_failed++; $display("FAIL rd_beat%0d: got %0h last %0b expected %0h last %0b", i, got_q[i], last_q[i], exp_q[i], i == 3);
            end
        end
        tests_run++;
        if (first_cen != 1 || first_valid != 3) begin tests_failed++; $display("FAIL rd_latency: got cen %0d valid %0d expected 1 3", first_cen, first_valid); end
        tests_run++;
        if (first_pop != 3 || last_pop != 6) begin tests_failed++; $display("FAIL rd_throughput: got pops %0d..%0d expected 3..6", first_pop, last_pop); end
        tests_run++;
        if (done_cyc != 7 || done_cnt != 1 || err_cnt != 0) begin tests_failed++; $display("FAIL rd_done: got cycle %0d count %0d err %0d expected 7 1 0", done_cyc, done_cnt, err_cnt); end
    endtask

    task automatic test_backpressure();
        run_read(4'd0, 4'd7, 1, 0);
        exp_q = '{32'h100, 32'h101, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h106, 32'h107};
        tests_run++;
        if (timed_out || got_q.size() != 8) begin tests_failed++; $display("FAIL bp_count: got %0d beats timeout %0b expected 8 0", got_q.size(), timed_out); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 7)) begin
                tests_failed++; $display("FAIL bp_beat%0d: got %0h last %0b expected %0h last %0b", i, got_q[i], last_q[i], exp_q[i], i == 7);
            end
        end
        tests_run++;
        if (max_out > 2 || !stall_seen) begin tests_failed++; $display("FAIL bp_outstanding: got max %0d stall %0b expected <=2 1", max_out, stall_seen); end
        tests_run++;
        if (addr_seen.size() != 8 || done_cnt != 1 || done_cyc != last_pop + 1) begin
            tests_failed++; $display("FAIL bp_done: got issues %0d done %0d at %0d expected 8 1 at %0d", addr_seen.size(), done_cnt, done_cyc, last_pop + 1);
        end
    endtask

    task automatic test_wrap();
        run_read(4'd14, 4'd3, 0, 0);
`ifdef RAM_BURST_BOUND_CHECK_EN
        tests_run++;
        if (addr_seen.size() != 0 || got_q.size() != 0) begin tests_failed++; $display("FAIL wrap_reject_access: got %0d issues %0d beats expected 0 0", addr_seen.size(), got_q.size()); end
        tests_run++;
        if (err_cyc != 1 || done_cyc != 1 || err_cnt != 1 || done_cnt != 1) begin
            tests_failed++; $display("FAIL wrap_reject_pulse: got err %0d(x%0d) done %0d(x%0d) expected 1 1", err_cyc, err_cnt, done_cyc, done_cnt);
        end
`else
        exp_q = '{32'h10E, 32'h10F, 32'h100, 32'h101};
        tests_run++;
        if (addr_seen.size() != 4 || got_q.size() != 4 || err_cnt != 0) begin
            tests_failed++; $display("FAIL wrap_count: got %0d issues %0d beats err %0d expected 4 4 0", addr_seen.size(), got_q.size(), err_cnt);
        end
        for (int i = 0; i < 4 && i < addr_seen.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (addr_seen[i] !== AW'(14 + i) || got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL wrap_beat%0d: got addr %0d data %0h expected %0d %0h", i, addr_seen[i], got_q[i], (14 + i) % 16, exp_q[i]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        run_read(4'd2, 4'd3, 0, 2);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.rd_valid, bus.busy, bus.ram_cen, bus.done} !== 4'b0000) begin
            tests_failed++; $display("FAIL rst_mid_outputs: got valid/busy/cen/done %b expected 0000", {bus.rd_valid, bus.busy, bus.ram_cen, bus.done});
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_release: got ready %b busy %b done %b expected 1 0 0", bus.cmd_ready, bus.busy, bus.done);
        end
        run_read(4'd2, 4'd3, 0, 0);
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        tests_run++;
        if (got_q.size() != 4 || done_cnt != 1) begin tests_failed++; $display("FAIL rst_mid_reread: got %0d beats %0d done expected 4 1", got_q.size(), done_cnt); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rst_mid_beat%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        clear_obs();
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'd8; bus.cmd_len = 4'd1;
        bus.rd_ready = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clock); #1;
            bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = DW'(32'hB0 + c - 1);
        end
        @(posedge clock); #1;
        bus.wr_valid = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd8; bus.cmd_len = 4'd1;
        @(negedge clock);
        tests_run++;
        if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_cycle: got done %b ready %b expected 1 1", bus.done, bus.cmd_ready); end
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.done, bus.busy} !== {1'b1, 1'b0, 4'd8, 1'b0, 1'b1}) begin
            tests_failed++; $display("FAIL b2b_second_start: got cen %b wen %b addr %0d done %b busy %b expected 1 0 8 0 1", bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.done, bus.busy);
        end
        dones = 0;
        for (int c = 5; c <= 12; c++) begin
            @(negedge clock);
            if (bus.rd_valid && bus.rd_ready) begin got_q.push_back(bus.rd_data); last_q.push_back(bus.rd_last); end
            if (bus.done) begin dones++; if (done_cyc < 0) done_cyc = c; end
        end
        exp_q = '{32'hB0, 32'hB1};
        tests_run++;
        if (got_q.size() != 2 || dones != 1 || done_cyc != 8) begin
            tests_failed++; $display("FAIL b2b_read_done: got %0d beats %0d done at %0d expected 2 1 at 8", got_q.size(), dones, done_cyc);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 1)) begin
                tests_failed++; $display("FAIL b2b_beat%0d: got %0h last %0b expected %0h last %0b", i, got_q[i], last_q[i], exp_q[i], i == 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ram_preload = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        test_reset();
        reset = 1'b0; ram_preload = 1'b0;
        test_write_burst();
        test_read_burst();
        test_backpressure();
        test_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog");
    end
endmodule
